// File: rtl/cram_loader_pkg.sv
//------------------------------------------------------------------------------
// Module : cram_loader_pkg
// Brief  : Shared constants and enumerations for the CRAM diagnostic loader.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package cram_loader_pkg;

  localparam int CRAM_WORDS = 2048;
  localparam int CRAM_WIDTH = 84;
  localparam int CRAM_CHUNK = 28;
  localparam int CRAM_ADR_W = $clog2(CRAM_WORDS);

  typedef enum logic [1:0] {
    OP_SETADR = 2'd0,
    OP_LOAD   = 2'd1,
    OP_WRITE  = 2'd2,
    OP_READ   = 2'd3
  } cram_loader_op_t;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_WR   = 4'd1,
    ST_RD   = 4'd2,
    ST_RDW  = 4'd3,
    ST_RSP0 = 4'd4,
    ST_RSP1 = 4'd5,
    ST_RSP2 = 4'd6,
    ST_VRD  = 4'd7,
    ST_VCMP = 4'd8
  } cram_loader_state_t;

endpackage

`default_nettype wire

// File: rtl/cram_loader.sv
//------------------------------------------------------------------------------
// Module : cram_loader
// Brief  : Diagnostic writer/reader for the 2K x 84-bit control RAM. Assembles
//          three 28-bit chunks into a microword, writes it at an auto-
//          incrementing address, and reads words back out in chunks.
//          Optional macro CRAM_LOADER_VERIFY_EN adds a read-after-write
//          verify pass with a sticky mismatch flag.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module cram_loader
  import cram_loader_pkg::*;
(
  input  logic                    CLK,
  input  logic                    RESET_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [0:35]             cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [0:35]             rsp_data,
  output logic [0:CRAM_ADR_W-1]   cram_adr,
  output logic [0:CRAM_WIDTH-1]   cram_din,
  output logic                    cram_we,
  input  logic [0:CRAM_WIDTH-1]   cram_dout,
  output logic                    busy,
  output logic                    verify_err
);

  cram_loader_state_t           r_state;
  cram_loader_state_t           w_next_state;
  cram_loader_op_t              w_op;
  logic                         w_cmd_fire;
  logic [0:CRAM_ADR_W-1]        r_adr;
  logic [1:0]                   r_cp;
  logic [0:CRAM_WIDTH-1]        r_hold;
  logic [0:CRAM_WIDTH-1]        r_rd;
  logic                         w_unused_ok;

  assign w_op        = cram_loader_op_t'(cmd_op);
  assign w_cmd_fire  = cmd_valid && (r_state == ST_IDLE);
  // The top byte of the payload carries nothing for any op
  assign w_unused_ok = ^cmd_data[0:7];

  assign cram_adr = r_adr;
  assign cram_din = r_hold;
  assign busy     = (r_state != ST_IDLE);

  // State register
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state decode and handshake/strobe outputs
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    cram_we      = 1'b0;
    rsp_valid    = 1'b0;
    rsp_data     = '0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (w_op == OP_WRITE)     w_next_state = ST_WR;
          else if (w_op == OP_READ) w_next_state = ST_RD;
        end
      end
      ST_WR: begin
        cram_we = 1'b1;
`ifdef CRAM_LOADER_VERIFY_EN
        w_next_state = ST_VRD;
`else
        w_next_state = ST_IDLE;
`endif
      end
`ifdef CRAM_LOADER_VERIFY_EN
      ST_VRD:  w_next_state = ST_VCMP;
      ST_VCMP: w_next_state = ST_IDLE;
`endif
      ST_RD:  w_next_state = ST_RDW;
      ST_RDW: w_next_state = ST_RSP0;
      ST_RSP0: begin
        rsp_valid = 1'b1;
        rsp_data  = {8'h00, r_rd[0:27]};
        if (rsp_ready) w_next_state = ST_RSP1;
      end
      ST_RSP1: begin
        rsp_valid = 1'b1;
        rsp_data  = {8'h00, r_rd[28:55]};
        if (rsp_ready) w_next_state = ST_RSP2;
      end
      ST_RSP2: begin
        rsp_valid = 1'b1;
        rsp_data  = {8'h00, r_rd[56:83]};
        if (rsp_ready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Address, chunk pointer, holding and readback registers
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_adr  <= '0;
      r_cp   <= 2'd0;
      r_hold <= '0;
      r_rd   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            case (w_op)
              OP_SETADR: begin
                r_adr <= cmd_data[25:35];
                r_cp  <= 2'd0;
              end
              OP_LOAD: begin
                case (r_cp)
                  2'd0:    r_hold[0:27]  <= cmd_data[8:35];
                  2'd1:    r_hold[28:55] <= cmd_data[8:35];
                  default: r_hold[56:83] <= cmd_data[8:35];
                endcase
                r_cp <= (r_cp == 2'd2) ? 2'd0 : r_cp + 2'd1;
              end
              default: ;
            endcase
          end
        end
        ST_WR: begin
          r_cp <= 2'd0;
`ifndef CRAM_LOADER_VERIFY_EN
          r_adr <= r_adr + 1'b1;
`endif
        end
`ifdef CRAM_LOADER_VERIFY_EN
        // Address advances only once the verify compare is done
        ST_VCMP: r_adr <= r_adr + 1'b1;
`endif
        ST_RDW: r_rd <= cram_dout;
        ST_RSP2: begin
          if (rsp_ready) r_adr <= r_adr + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CRAM_LOADER_VERIFY_EN
  logic r_verify_err;

  // Sticky mismatch flag: set by a failed verify, cleared by SETADR
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_verify_err <= 1'b0;
    end else if (w_cmd_fire && (w_op == OP_SETADR)) begin
      r_verify_err <= 1'b0;
    end else if ((r_state == ST_VCMP) && (cram_dout != r_hold)) begin
      r_verify_err <= 1'b1;
    end
  end

  assign verify_err = r_verify_err;
`else
  assign verify_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cram_loader.sv
//------------------------------------------------------------------------------
// Module : tb_cram_loader
// Brief  : Self-checking bench for cram_loader with a word-level CRAM model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cram_loader;

  logic        CLK = 1'b0;
  logic        RESET_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [0:35] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:35] rsp_data;
  logic [0:10] cram_adr;
  logic [0:83] cram_din;
  logic        cram_we;
  logic [0:83] cram_dout;
  logic        busy;
  logic        verify_err;

  cram_loader dut (
    .CLK(CLK), .RESET_n(RESET_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .cram_adr(cram_adr), .cram_din(cram_din), .cram_we(cram_we), .cram_dout(cram_dout),
    .busy(busy), .verify_err(verify_err)
  );

  always #5 CLK = ~CLK;

  // CRAM: synchronous write, registered read (data one clock after address)
  logic [83:0] mem [2048];
  always @(posedge CLK) begin
    if (cram_we) mem[cram_adr] <= cram_din;
`ifdef CRAM_LOADER_VERIFY_EN
    cram_dout <= mem[cram_adr] & ~(84'd1 << 43);   // CRAM bit 40 stuck at 0
`else
    cram_dout <= mem[cram_adr];
`endif
  end

  // Transaction-level model
  logic [83:0] exp_mem [2048];
  logic [27:0] mh [3];
  int          m_cp;
  logic [10:0] m_adr;
  logic        m_verr;
  logic        exp_we, exp_busy, exp_ready, exp_rv;
  logic [35:0] exp_rdata;
  logic        chk_on;
  logic [83:0] last_din;
  logic [10:0] last_wadr;
  logic [35:0] got [3];

  int n_pass = 0;
  int n_tot  = 0;

  function automatic logic [83:0] hold_word();
    return {mh[0], mh[1], mh[2]};
  endfunction

  task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("cram_adr", cram_adr, m_adr);
      chk("cram_we", cram_we, exp_we);
      if (exp_we) chk("cram_din", cram_din, hold_word());
      chk("busy", busy, exp_busy);
      chk("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) chk("rsp_data", rsp_data, exp_rdata);
      chk("verify_err", verify_err, m_verr);
      if (RESET_n) chk("cmd_ready", cmd_ready, exp_ready);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_exp();
    exp_we = 0; exp_busy = 0; exp_ready = 1; exp_rv = 0;
  endtask

  task automatic model_reset();
    m_adr = '0; m_cp = 0; m_verr = 0;
    for (int i = 0; i < 3; i++) mh[i] = '0;
    idle_exp();
  endtask

  task automatic cmd(input logic [1:0] op, input logic [35:0] d);
    logic [83:0] w;
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    step();
    cmd_valid = 0;
    case (op)
      2'd0: begin m_adr = d[10:0]; m_cp = 0; m_verr = 0; end
      2'd1: begin mh[m_cp] = d[27:0]; m_cp = (m_cp == 2) ? 0 : m_cp + 1; end
      2'd2: begin
        w = hold_word();
        exp_we = 1; exp_busy = 1; exp_ready = 0;
        exp_mem[m_adr] = w;
        last_din = cram_din; last_wadr = cram_adr;
        step();
        exp_we = 0;
`ifdef CRAM_LOADER_VERIFY_EN
        step();
        step();
        m_verr = m_verr | w[43];
`endif
        m_adr = m_adr + 1'b1; m_cp = 0;
        idle_exp();
      end
      default: ;
    endcase
  endtask

  // READ with optional stalling and optional reset abort during the second chunk
  task automatic rd(input bit toggle, input bit abort, output bit aborted);
    int k;
    int cyc;
    aborted = 0;
    cmd_valid = 1; cmd_op = 2'd3; cmd_data = '0;
    step();
    cmd_valid = 0;
    exp_busy = 1; exp_ready = 0;
    step();
    step();
    k = 0; cyc = 0;
    while (k < 3) begin
      exp_rv = 1;
      exp_rdata = {8'h00, exp_mem[m_adr][83 - 28*k -: 28]};
      rsp_ready = toggle ? cyc[0] : 1'b1;
      cyc++;
      if (abort && k == 1) begin
        #2;
        RESET_n = 0;
        model_reset();
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_adr", cram_adr, 0);
        rsp_ready = 0;
        aborted = 1;
        return;
      end
      if (rsp_ready) got[k] = rsp_data;
      step();
      if (rsp_ready) k++;
    end
    rsp_ready = 0;
    m_adr = m_adr + 1'b1;
    idle_exp();
  endtask

  initial begin
    bit ab;
    for (int i = 0; i < 2048; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    chk_on = 0;
    RESET_n = 0; cmd_valid = 0; cmd_op = 0; cmd_data = '0; rsp_ready = 0;
    model_reset();
    #2 chk_on = 1;
    repeat (3) step();
    RESET_n = 1;
    step();
    chk("cmd_ready_after_reset", cmd_ready, 1);

    // Basic assemble and write at 5
    cmd(2'd0, 36'h005);
    cmd(2'd1, 36'h0AAAAAAA);
    cmd(2'd1, 36'h05555555);
    cmd(2'd1, 36'h0123ABCD);
    cmd(2'd2, '0);
    chk("w1_din", last_din, 84'hAAAAAAA_5555555_123ABCD);
    chk("w1_adr", last_wadr, 11'h005);
    chk("w1_adr_next", cram_adr, 11'h006);
    chk("w1_mem", mem[5], 84'hAAAAAAA_5555555_123ABCD);

    // Address wrap across two writes
    cmd(2'd0, 36'h7FF);
    cmd(2'd1, 36'h0FEDCBA);
    cmd(2'd1, 36'h0000001);
    cmd(2'd1, 36'h7654321);
    cmd(2'd2, '0);
    cmd(2'd2, '0);
    chk("wrap_mem_7ff", mem[11'h7FF], 84'h0FEDCBA_0000001_7654321);
    chk("wrap_mem_000", mem[0], 84'h0FEDCBA_0000001_7654321);
    chk("wrap_adr", cram_adr, 11'h001);

    // Stalled readback of address 5
    cmd(2'd0, 36'h005);
    rd(1'b1, 1'b0, ab);
    chk("rd_chunk0", got[0], 36'h00AAAAAAA);
    chk("rd_chunk1", got[1], 36'h005555555);
    chk("rd_chunk2", got[2], 36'h00123ABCD);
    chk("rd_adr_next", cram_adr, 11'h006);

    // Fourth LOAD overwrites chunk 0
    cmd(2'd0, 36'h020);
    cmd(2'd1, 36'h1111111);
    cmd(2'd1, 36'h2222222);
    cmd(2'd1, 36'h3333333);
    cmd(2'd1, 36'h4444444);
    cmd(2'd2, '0);
    chk("load4_mem", mem[11'h020], 84'h4444444_2222222_3333333);

`ifdef CRAM_LOADER_VERIFY_EN
    // Word with CRAM bit 40 set against a stuck-at-0 memory
    cmd(2'd0, 36'h030);
    cmd(2'd1, 36'h0000000);
    cmd(2'd1, 36'h0008000);
    cmd(2'd1, 36'h0000000);
    cmd(2'd2, '0);
    chk("verify_err_set", verify_err, 1);
    cmd(2'd0, 36'h031);
    chk("verify_err_clr", verify_err, 0);
`endif

    // Reset abort in the middle of a readback
    cmd(2'd0, 36'h005);
    rd(1'b0, 1'b1, ab);
    chk("abort_taken", ab, 1);
    repeat (2) step();
    RESET_n = 1;
    repeat (4) step();
    chk("post_abort_ready", cmd_ready, 1);

    chk_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cram_loader.md
# cram_loader

Diagnostic-side writer/reader for the 2K × 84-bit control RAM. It accepts load commands from the diagnostic/front-end command channel and assembles three 28-bit chunks into an 84-bit microword. It commits each microword to the CRAM write port at an auto-incrementing address, and can read words back out in chunks. It owns the CRAM port only while the EBOX is halted; the microcode fetch path is the normal reader of the same storage.

## Interface
- No parameters. CRAM geometry is fixed at 2048 words × 84 bits, from package constants.
- `CLK` in 1: single clock, same as the CRM clock.
- `RESET_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 2: 0=SETADR, 1=LOAD, 2=WRITE, 3=READ.
- `cmd_data` in [0:35]: command payload, 36-bit, big-endian bit numbering.
- `rsp_valid` out 1: readback chunk valid.
- `rsp_ready` in 1: consumer accepts chunk.
- `rsp_data` out [0:35]: readback chunk; bits [0:7] are zero, [8:35] are the chunk.
- `cram_adr` out [0:10]: CRAM address.
- `cram_din` out [0:83]: CRAM write data.
- `cram_we` out 1: CRAM write enable.
- `cram_dout` in [0:83]: CRAM read data, valid one `CLK` after the address.
- `busy` out 1: high in any state other than IDLE.
- `verify_err` out 1: sticky readback-mismatch flag.

## Operation
- The holding register `hold[0:83]`, address register `adr[0:10]` and chunk pointer `cp` (0..2) are internal.
- SETADR: `adr <= cmd_data[25:35]`; `cp <= 0`; clears `verify_err`.
- LOAD: `cmd_data[8:35]` goes into chunk `cp`:
  - chunk 0 → `hold[0:27]`, chunk 1 → `hold[28:55]`, chunk 2 → `hold[56:83]`.
  - `cp` advances modulo 3, so a 4th LOAD overwrites chunk 0.
- WRITE:
  - Drives `cram_adr=adr`, `cram_din=hold`, `cram_we=1` for exactly one cycle.
  - Then `adr <= adr+1` (2047 wraps to 0) and `cp <= 0`.
  - `hold` is retained, so repeated WRITEs fill a region with one word.
- READ:
  - Presents `adr`, waits one cycle for `cram_dout`, and latches it into a separate read register.
  - Emits chunks 0, 1, 2 in order on the response channel.
  - Then `adr <= adr+1` with wrap. `hold` is not disturbed.
- FSM states and transitions:
  - IDLE → WR (WRITE) or RD (READ). SETADR and LOAD complete in IDLE in one cycle.
  - WR → IDLE.
  - RD → RDW → RSP0 → RSP1 → RSP2 → IDLE. Each RSPn holds until `rsp_ready`.
- Response handshake:
  - `cmd_ready` = (state==IDLE).
  - `rsp_valid` is high only in RSP0..2.
  - `rsp_data` is stable while `rsp_valid & !rsp_ready`.
- `cram_we` is never asserted outside WR.
- `cram_adr` shows `adr` in every state.

## Timing
- Reset values: state IDLE, `adr=0`, `cp=0`, `hold=0`, read register 0, `cram_we=0`, `rsp_valid=0`, `busy=0`, `verify_err=0`. `cmd_ready=1` after reset deasserts.
- SETADR/LOAD: one-cycle throughput. A new value is visible on the next `CLK`.
- WRITE: accept at cycle N, `cram_we` high in N+1, `adr` increments at the end of N+1, `cmd_ready` high again at N+2.
- READ: accept at N, address at N+1, `cram_dout` captured at the end of N+2, first `rsp_valid` at N+3. With `rsp_ready` held high, the last chunk is at N+5.
- Reset asserted mid-operation aborts immediately to reset values. A partially emitted readback is discarded, and `cram_we` drops asynchronously.
- Unknown conditions do not exist: all four op codes are defined.

## Configuration
- `CRAM_LOADER_VERIFY_EN` defined:
  - WRITE inserts states VRD (re-present the same address, `we=0`) and VCMP (compare `cram_dout` to `hold`) before returning to IDLE.
  - A mismatch sets `verify_err`. `adr` increments after VCMP.
  - WRITE occupancy becomes 3 cycles, so `cmd_ready` returns at N+4.
- Undefined: no verify states, and `verify_err` is tied to 0.

## Structure
- A shared package holds:
  - `CRAM_WORDS=2048`, `CRAM_WIDTH=84`, `CRAM_CHUNK=28`;
  - an enum `cram_loader_op_t` for the op codes;
  - an enum for the FSM states.
- The FSM and all registers live in one module. No sub-module is needed. The CRAM itself stays external, shared with the microcode fetch path via an ownership mux outside this block.

## Test plan
- Reset, then SETADR 0x005, LOAD 0x0AAAAAAA, 0x05555555, 0x0123ABCD, WRITE → one `cram_we` pulse at adr 5 with din = those chunks concatenated; `adr` becomes 6.
- SETADR 0x7FF, LOAD×3, WRITE, WRITE → writes land at 0x7FF and 0x000; `adr` ends at 1.
- SETADR 5, READ with `rsp_ready` toggling every other cycle → three chunks 0x00AAAAAAA, 0x005555555, 0x00123ABCD, each held stable while stalled.
- Four LOADs (values A, B, C, D) then WRITE → chunk0=D, chunk1=B, chunk2=C.
- With `CRAM_LOADER_VERIFY_EN`, a memory model forcing bit 40 stuck-at-0 and a written word with bit 40=1 → `verify_err`=1 after VCMP; next SETADR clears it.
- Assert `RESET_n` low during RSP1 → `rsp_valid`=0 and `adr`=0 immediately; after release, `cmd_ready`=1 and no `cram_we` pulse occurs.
